// File: rtl/core_pipe_exec_lsu_split_if.sv
// rtl/core_pipe_exec_lsu_split_if.sv - single-channel data memory bus between the LSU and memory
interface core_pipe_exec_lsu_split_if #(
  parameter int XLEN = 64
);
  logic                  dmem_req;
  logic [XLEN-1:0]       dmem_addr;
  logic                  dmem_wen;
  logic [XLEN/8-1:0]     dmem_strb;
  logic [XLEN-1:0]       dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_err;
  logic [XLEN-1:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_err, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_err, dmem_rdata
  );
endinterface

// File: rtl/core_pipe_exec_lsu_split.sv
// rtl/core_pipe_exec_lsu_split.sv - execute-stage LSU; CORE_LSU_MISALIGN_EN enables split beats for misaligned accesses
module core_pipe_exec_lsu_split #(
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            valid,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            load,
  input  logic            store,
  input  logic [1:0]      size,
  input  logic            sext,
  output logic            ready,
  output logic            trap_bus,
  output logic            trap_addr,
  output logic [XLEN-1:0] rdata,
  core_pipe_exec_lsu_split_if.master dmem
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(XLEN);

`ifdef CORE_LSU_MISALIGN_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_HI = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t state_q, state_d;

  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
  logic              req_c;
  logic              fin;

  logic [OFFW-1:0]   off;
  logic [OFFW+1:0]   nb;
  logic [OFFW+4:0]   nbits;
  logic [OFFW+4:0]   sidx;
  logic [OFFW+2:0]   lo_sh;
  logic [XLEN-1:0]   base_addr;
  logic [BYTES-1:0]  strb_base;
  logic [BYTES-1:0]  strb_lo;
  logic [XLEN-1:0]   wd_lo;
  logic [XLEN-1:0]   rd_raw;
  logic [XLEN-1:0]   ld_mask;
  logic              sbit;
  logic [XLEN-1:0]   rd_ext;

  // Access geometry: byte offset in the bus word, byte count and first-beat lanes
  always_comb begin
    off       = addr[OFFW-1:0];
    nb        = (OFFW+2)'(1) << size;
    nbits     = {nb, 3'b000};
    lo_sh     = {off, 3'b000};
    base_addr = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    strb_base = ~({BYTES{1'b1}} << nb);
    strb_lo   = strb_base << off;
    wd_lo     = wdata << lo_sh;
  end

`ifdef CORE_LSU_MISALIGN_EN
  logic [XLEN-1:0]   cap_q;
  logic              cross;
  logic [AW:0]       hi_sh;
  logic [BYTES-1:0]  strb_hi;
  logic [XLEN-1:0]   wd_hi;

  // Second-beat geometry for accesses that run past the end of the bus word
  always_comb begin
    cross   = ({2'b00, off} + nb) > (OFFW+2)'(BYTES);
    hi_sh   = (AW+1)'(XLEN) - (AW+1)'(lo_sh);
    strb_hi = strb_base >> ((OFFW+1)'(BYTES) - (OFFW+1)'(off));
    wd_hi   = wdata >> hi_sh;
    trap_addr = 1'b0;
  end

  // Read assembly: the low beat is the captured word once we are in HI
  always_comb begin
    if (state_q == S_HI) begin
      rd_raw = (cap_q >> lo_sh) | (dmem.dmem_rdata << hi_sh);
    end else begin
      rd_raw = dmem.dmem_rdata >> lo_sh;
    end
  end
`else
  logic [OFFW+1:0]   nbm1;

  // Misaligned accesses are refused outright; read data is always a single beat
  always_comb begin
    nbm1      = nb - (OFFW+2)'(1);
    trap_addr = valid && (|(addr[OFFW+1:0] & nbm1));
    rd_raw    = dmem.dmem_rdata >> lo_sh;
  end
`endif

  // Mask to the access size and extend; a full-width access has an all-ones mask
  always_comb begin
    ld_mask = ~({XLEN{1'b1}} << nbits);
    sidx    = nbits - (OFFW+5)'(1);
    sbit    = sext && rd_raw[sidx[AW-1:0]];
    rd_ext  = (rd_raw & ld_mask) | ({XLEN{sbit}} & ~ld_mask);
  end

  // Next-state and bus drive; DONE keeps the bus quiet so a held valid cannot re-issue
  always_comb begin
    state_d         = state_q;
    req_c           = 1'b0;
    fin             = 1'b0;
    dmem.dmem_addr  = base_addr;
    dmem.dmem_strb  = strb_lo;
    dmem.dmem_wdata = wd_lo;
    dmem.dmem_wen   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_c         = valid && !trap_addr;
        dmem.dmem_wen = store;
        if (req_c && dmem.dmem_gnt) begin
`ifdef CORE_LSU_MISALIGN_EN
          if (dmem.dmem_err || !cross) begin
            fin     = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_HI;
          end
`else
          fin     = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
`ifdef CORE_LSU_MISALIGN_EN
      S_HI: begin
        req_c           = 1'b1;
        dmem.dmem_addr  = base_addr + XLEN'(BYTES);
        dmem.dmem_strb  = strb_hi;
        dmem.dmem_wdata = wd_hi;
        dmem.dmem_wen   = store;
        if (dmem.dmem_gnt) begin
          fin     = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Reset pulls the request down at once, even with valid still held
    dmem.dmem_req = req_c && g_resetn;
  end

  // State, error flag and load result registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_c && dmem.dmem_gnt) begin
        err_q <= dmem.dmem_err;
`ifdef CORE_LSU_MISALIGN_EN
      end else if (state_q == S_HI && dmem.dmem_gnt) begin
        err_q <= err_q | dmem.dmem_err;
`endif
      end
      if (fin && load) begin
        rdata_q <= rd_ext;
      end
    end
  end

`ifdef CORE_LSU_MISALIGN_EN
  // Low beat of a crossing access, held until the high beat arrives
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cap_q <= '0;
    end else if (state_q == S_IDLE && req_c && dmem.dmem_gnt && !dmem.dmem_err && cross) begin
      cap_q <= dmem.dmem_rdata;
    end
  end
`endif

  assign ready    = (state_q == S_DONE);
  assign trap_bus = err_q && ready;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_core_pipe_exec_lsu_split.sv
// tb/tb_core_pipe_exec_lsu_split.sv - directed self-checking bench for core_pipe_exec_lsu_split
module tb_core_pipe_exec_lsu_split;

  logic        g_clk;
  logic        g_resetn;
  logic        valid;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        load;
  logic        store;
  logic [1:0]  size;
  logic        sext;
  logic        ready;
  logic        trap_bus;
  logic        trap_addr;
  logic [63:0] rdata;

  int n_vec = 0;
  int n_bad = 0;

  core_pipe_exec_lsu_split_if #(.XLEN(64)) dmem ();

  core_pipe_exec_lsu_split #(.XLEN(64)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .valid     (valid),
    .addr      (addr),
    .wdata     (wdata),
    .load      (load),
    .store     (store),
    .size      (size),
    .sext      (sext),
    .ready     (ready),
    .trap_bus  (trap_bus),
    .trap_addr (trap_addr),
    .rdata     (rdata),
    .dmem      (dmem)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [63:0] a, input logic [63:0] wd, input logic ld,
                         input logic [1:0] sz, input logic sx);
    valid = 1'b1;
    addr  = a;
    wdata = wd;
    load  = ld;
    store = !ld;
    size  = sz;
    sext  = sx;
  endtask

  task automatic clr_req();
    valid = 1'b0;
    load  = 1'b0;
    store = 1'b0;
  endtask

  initial begin
    g_resetn = 1'b0;
    valid = 1'b0; addr = '0; wdata = '0; load = 1'b0; store = 1'b0; size = 2'd0; sext = 1'b0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_err = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(negedge g_clk);
    check("rst_ready", ready, 1'b0);
    check("rst_req", dmem.dmem_req, 1'b0);
    check("rst_trap_bus", trap_bus, 1'b0);
    g_resetn = 1'b1;
    @(negedge g_clk);

    // load word sext at 0x1004, gnt in the request cycle
    set_req(64'h1004, 64'h0, 1'b1, 2'd2, 1'b1);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'h8000_0001_1234_5678;
    #1;
    check("lw_req", dmem.dmem_req, 1'b1);
    check("lw_addr", dmem.dmem_addr, 64'h1000);
    check("lw_strb", dmem.dmem_strb, 8'hF0);
    check("lw_wen", dmem.dmem_wen, 1'b0);
    check("lw_ready_early", ready, 1'b0);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("lw_ready", ready, 1'b1);
    check("lw_rdata", rdata, 64'hFFFF_FFFF_8000_0001);
    check("lw_trap_bus", trap_bus, 1'b0);
    check("lw_done_req", dmem.dmem_req, 1'b0);
    @(negedge g_clk);
    check("lw_ready_once", ready, 1'b0);
    clr_req();
    @(negedge g_clk);

    // store half at 0x2006 with one wait state
    set_req(64'h2006, 64'hBEEF, 1'b0, 2'd1, 1'b0);
    #1;
    check("sh_req", dmem.dmem_req, 1'b1);
    check("sh_addr", dmem.dmem_addr, 64'h2000);
    check("sh_strb", dmem.dmem_strb, 8'hC0);
    check("sh_wdata", dmem.dmem_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_wen", dmem.dmem_wen, 1'b1);
    @(negedge g_clk);
    check("sh_wait_req", dmem.dmem_req, 1'b1);
    check("sh_wait_addr", dmem.dmem_addr, 64'h2000);
    check("sh_wait_ready", ready, 1'b0);
    dmem.dmem_gnt = 1'b1;
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("sh_ready", ready, 1'b1);
    check("sh_trap_bus", trap_bus, 1'b0);
    clr_req();
    @(negedge g_clk);

    // load half unsigned at 0x12
    set_req(64'h12, 64'h0, 1'b1, 2'd1, 1'b0);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'h1111_2222_CAFE_3333;
    #1;
    check("lhu_strb", dmem.dmem_strb, 8'h0C);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("lhu_ready", ready, 1'b1);
    check("lhu_rdata", rdata, 64'h0000_0000_0000_CAFE);
    clr_req();
    @(negedge g_clk);

    // aligned store word with bus error
    set_req(64'h20, 64'h1234_5678, 1'b0, 2'd2, 1'b0);
    dmem.dmem_gnt = 1'b1; dmem.dmem_err = 1'b1;
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0; dmem.dmem_err = 1'b0;
    check("sw_err_ready", ready, 1'b1);
    check("sw_err_trap_bus", trap_bus, 1'b1);
    clr_req();
    @(negedge g_clk);

    // misaligned non-crossing load word at 0x1002
    set_req(64'h1002, 64'h0, 1'b1, 2'd2, 1'b1);
    dmem.dmem_rdata = 64'h0123_4567_89AB_CDEF;
`ifdef CORE_LSU_MISALIGN_EN
    dmem.dmem_gnt = 1'b1;
    #1;
    check("mis_trap_addr", trap_addr, 1'b0);
    check("mis_req", dmem.dmem_req, 1'b1);
    check("mis_strb", dmem.dmem_strb, 8'h3C);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("mis_ready", ready, 1'b1);
    check("mis_rdata", rdata, 64'h0000_0000_4567_89AB);
    clr_req();
    @(negedge g_clk);
`else
    dmem.dmem_gnt = 1'b1;
    #1;
    check("mis_trap_addr", trap_addr, 1'b1);
    check("mis_req", dmem.dmem_req, 1'b0);
    begin
      logic saw_ready;
      saw_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge g_clk);
        if (ready) saw_ready = 1'b1;
      end
      check("mis_no_ready", saw_ready, 1'b0);
    end
    dmem.dmem_gnt = 1'b0;
    clr_req();
    @(negedge g_clk);
`endif

`ifdef CORE_LSU_MISALIGN_EN
    // crossing load double at 0x3005
    set_req(64'h3005, 64'h0, 1'b1, 2'd3, 1'b0);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'h8877_6655_4433_2211;
    #1;
    check("ld_x_addr0", dmem.dmem_addr, 64'h3000);
    check("ld_x_strb0", dmem.dmem_strb, 8'hE0);
    @(negedge g_clk);
    dmem.dmem_rdata = 64'h0000_0000_00CC_BBAA;
    #1;
    check("ld_x_ready_mid", ready, 1'b0);
    check("ld_x_req1", dmem.dmem_req, 1'b1);
    check("ld_x_addr1", dmem.dmem_addr, 64'h3008);
    check("ld_x_strb1", dmem.dmem_strb, 8'h1F);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("ld_x_ready", ready, 1'b1);
    check("ld_x_rdata", rdata, 64'h0000_CCBB_AA88_7766);
    clr_req();
    @(negedge g_clk);
    check("ld_x_ready_once", ready, 1'b0);

    // crossing store double with error on the first beat
    set_req(64'h3005, 64'h1122_3344_5566_7788, 1'b0, 2'd3, 1'b0);
    #1;
    check("sd_x_wdata0", dmem.dmem_wdata, 64'h6677_8800_0000_0000);
    check("sd_x_wen", dmem.dmem_wen, 1'b1);
    dmem.dmem_gnt = 1'b1; dmem.dmem_err = 1'b1;
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0; dmem.dmem_err = 1'b0;
    check("sd_x_err_ready", ready, 1'b1);
    check("sd_x_err_trap_bus", trap_bus, 1'b1);
    check("sd_x_no_hi_req", dmem.dmem_req, 1'b0);
    clr_req();
    @(negedge g_clk);

    // reset while waiting in HI
    set_req(64'h3005, 64'h0, 1'b1, 2'd3, 1'b0);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'h8877_6655_4433_2211;
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    #1;
    check("rst_hi_req_before", dmem.dmem_req, 1'b1);
`else
    // reset while a request waits for gnt
    set_req(64'h40, 64'h0, 1'b1, 2'd3, 1'b0);
    @(negedge g_clk);
    #1;
    check("rst_wait_req_before", dmem.dmem_req, 1'b1);
`endif
    g_resetn = 1'b0;
    #1;
    check("rst_mid_req", dmem.dmem_req, 1'b0);
    check("rst_mid_ready", ready, 1'b0);
    clr_req();
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);

    // load byte sext at 0x47 after reset
    set_req(64'h47, 64'h0, 1'b1, 2'd0, 1'b1);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'h9A00_0000_0000_0000;
    #1;
    check("lb_strb", dmem.dmem_strb, 8'h80);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("lb_ready", ready, 1'b1);
    check("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF9A);
    clr_req();
    @(negedge g_clk);

    // aligned load double, no extension
    set_req(64'h18, 64'h0, 1'b1, 2'd3, 1'b1);
    dmem.dmem_gnt = 1'b1; dmem.dmem_rdata = 64'hF123_4567_89AB_CDEF;
    #1;
    check("ld_strb", dmem.dmem_strb, 8'hFF);
    @(negedge g_clk);
    dmem.dmem_gnt = 1'b0;
    check("ld_ready", ready, 1'b1);
    check("ld_rdata", rdata, 64'hF123_4567_89AB_CDEF);
    clr_req();
    @(negedge g_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
